// File: rtl/pipe_reg_mux_n.sv
// Parametrised 0..4 stage input register chain with per-stage valid tracking,
// synchronous flush, occupancy count and a runtime output tap select.

module pipe_reg_stage #(
    parameter int               WIDTH   = 18,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic             d_vld,
    output logic [WIDTH-1:0] q,
    output logic             q_vld
);
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            q     <= RST_VAL;
            q_vld <= 1'b0;
        end else if (ce) begin
            q     <= d;
            q_vld <= d_vld;
        end
    end
endmodule

module pipe_reg_mux_n #(
    parameter int               WIDTH   = 18,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       tap_sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [2:0]       fill_cnt,
    output logic             sel_err
);
    if (DEPTH < 0 || DEPTH > 4) begin : g_bad_depth
        $error("pipe_reg_mux_n: DEPTH must be 0..4");
    end
    if (WIDTH < 1 || WIDTH > 48) begin : g_bad_width
        $error("pipe_reg_mux_n: WIDTH must be 1..48");
    end

    assign sel_err = (tap_sel > 3'(DEPTH));

    if (DEPTH == 0) begin : g_bypass
        logic unused_ctl;
        assign unused_ctl = ^{clk, rst, ce, clr};
        assign out        = in;
        assign out_valid  = in_valid;
        assign fill_cnt   = 3'd0;
    end else begin : g_chain
        // Index 0 is the live input so tap_sel maps straight onto the pipe index.
        logic [DEPTH:0][WIDTH-1:0] data_pipe;
        logic [DEPTH:0]            vld_pipe;
        logic [DEPTH:1]            vld_nxt;
        logic [2:0]                cnt_nxt;
        logic [2:0]                tap;

        assign data_pipe[0] = in;
        assign vld_pipe[0]  = in_valid;

        for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
            pipe_reg_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
                .clk  (clk),
                .rst  (rst),
                .ce   (ce),
                .clr  (clr),
                .d    (data_pipe[k-1]),
                .d_vld(vld_pipe[k-1]),
                .q    (data_pipe[k]),
                .q_vld(vld_pipe[k])
            );
        end

        // Count the valid bits the stages will hold after this edge.
        always_comb begin
            vld_nxt = vld_pipe[DEPTH:1];
            if (!rst || clr)
                vld_nxt = '0;
            else if (ce)
                vld_nxt = vld_pipe[DEPTH-1:0];
            cnt_nxt = 3'd0;
            for (int k = 1; k <= DEPTH; k++)
                cnt_nxt = cnt_nxt + 3'(vld_nxt[k]);
        end

        always_ff @(posedge clk) begin
            fill_cnt <= cnt_nxt;
        end

        always_comb begin
            tap       = sel_err ? 3'(DEPTH) : tap_sel;
            out       = data_pipe[0];
            out_valid = vld_pipe[0];
            for (int k = 1; k <= DEPTH; k++) begin
                if (tap == 3'(k)) begin
                    out       = data_pipe[k];
                    out_valid = vld_pipe[k];
                end
            end
        end
    end
endmodule

// File: doc/pipe_reg_mux_n.md
Name: pipe_reg_mux_n

Overview:
Parametrised multi-stage input register for the DSP datapath. It generalises the single optional 8-bit input register to a WIDTH-bit chain of 0..4 register stages. A runtime tap select chooses any stage, or combinational bypass, as the output. The block adds per-stage valid tracking, a synchronous flush and an occupancy count, and feeds the pre-adder and multiplier operand paths.

Parameters:
WIDTH, 18, data width in bits (1..48)
DEPTH, 2, number of register stages implemented (0..4); elaboration error outside range
RST_VAL, 0, value loaded into every data stage on reset or flush (WIDTH bits)

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, synchronous and active-low
ce  input  1  clock enable; advances the whole chain when high
clr  input  1  synchronous flush, active-high
in_valid  input  1  qualifies in
in  input  WIDTH  data input
tap_sel  input  3  output tap: 0 = bypass, k = stage k output
out  output  WIDTH  selected data
out_valid  output  1  valid paired with out
fill_cnt  output  3  number of stages currently holding valid data
sel_err  output  1  high while tap_sel > DEPTH

Behaviour:
- Storage: data stages s[1..DEPTH] and valid bits v[1..DEPTH].
- Reset (rst=0 at posedge clk): all s[k] <= RST_VAL and all v[k] <= 0. Reset overrides ce and clr, so it acts even when ce=0.
- Outputs after reset:
  - out/out_valid follow the selected tap.
  - With tap_sel=0, out = in and out_valid = in_valid.
  - With tap_sel>=1, out = RST_VAL and out_valid = 0.
  - fill_cnt = 0.
- Flush (rst=1, clr=1): same effect as reset on s and v, independent of ce. Has priority over ce.
- Advance (rst=1, clr=0, ce=1):
  - s[1] <= in, v[1] <= in_valid.
  - s[k] <= s[k-1] and v[k] <= v[k-1] for k = 2..DEPTH.
  - Data shifts even when the valid bit is 0; there are no bubbles-squeeze semantics.
- Hold (rst=1, clr=0, ce=0): all s and v keep their values.
- Output mux (combinational):
  - tap_sel=0: out = in, out_valid = in_valid.
  - 1 <= tap_sel <= DEPTH: out = s[tap_sel], out_valid = v[tap_sel].
  - tap_sel > DEPTH: clamp to tap DEPTH and drive sel_err=1. When DEPTH=0 the clamp target is bypass.
- Latency: a word presented at in with ce=1 appears at tap k after exactly k ce-qualified rising edges. Cycles with ce=0 do not count.
- tap_sel may change any cycle. out switches in the same cycle with no pipeline of the select.
- fill_cnt: registered popcount of the next-state v vector, so it is consistent with v in the same cycle (range 0..DEPTH).
- DEPTH=0: no flops are instantiated. out = in, out_valid = in_valid, fill_cnt = 0. sel_err = 1 for any tap_sel != 0.
- Simultaneous rst=0 and clr=1: reset behaviour, identical result.
- Reset or flush mid-stream: every in-flight word is discarded. The next word enters stage 1 on the next ce edge.

Test Plan:
- Reset: WIDTH=18, DEPTH=2, RST_VAL=0x155, stream with ce=1, then rst=0 for one edge with ce=0 -> s1=s2=0x155, v=0, fill_cnt=0; tap_sel=2 gives out=0x155, out_valid=0.
- Latency: ce=1, in=1,2,3 with in_valid=1 on consecutive edges, tap_sel=2 -> out=1 two edges after the first input, then 2, then 3; fill_cnt goes 1,2,2.
- Stall: after loading 0xA at stage 1, hold ce=0 for 3 cycles with in=0xB -> stage 1 stays 0xA; with ce=1 the next edge moves 0xA to stage 2 and 0xB to stage 1.
- Flush versus ce: chain full (fill_cnt=2), clr=1 with ce=0 -> next edge gives fill_cnt=0, out_valid=0, out=RST_VAL at taps 1 and 2.
- Tap and clamp: DEPTH=2, tap_sel 0/1/2/5 switched in successive cycles with the chain static -> out = in, s1, s2, s2; sel_err = 0, 0, 0, 1.
- DEPTH=0 build: in=0x3FFFF, in_valid=1, tap_sel=3 -> out=0x3FFFF the same cycle, out_valid=1, sel_err=1, fill_cnt=0.
